vga_color_fader: RTL

Sits directly upstream of VGA_Controller and drives its 24-bit obj_color input. It accepts target colours from the LiteX control path through a valid/ready handshake and queues them in a small FIFO. Each target is reached by a per-channel linear ramp, one step per video frame, and is then held for a programmable number of frames before the next target is taken. All colour changes are frame-synchronous, so there is no mid-frame tearing.

---
 rtl/vga_pkg.sv | 41 ++++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/vga_color_fader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types and the per-channel stepping function for the VGA colour fader.
// Pure declarations: no state, no latency, no flow control.
package vga_pkg;

   localparam int COLOR_W = 24;
   localparam int CH_W    = 8;

   typedef struct packed {
      logic [CH_W-1:0] r;
      logic [CH_W-1:0] g;
      logic [CH_W-1:0] b;
   } rgb_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FADE,
      ST_HOLD
   } fader_state_t;

   // One ramp step of at most 'step' toward 'tgt'; the 9-bit math clamps at the target, so it never wraps.
   function automatic logic [CH_W-1:0] step_ch(input logic [CH_W-1:0] cur,
                                                 input logic [CH_W-1:0] tgt,
                                                 input logic [CH_W-1:0] step);
      logic [CH_W:0] nxt;
      nxt = {1'b0, cur};
      if (cur < tgt) begin
         nxt = {1'b0, cur} + {1'b0, step};
         if (nxt > {1'b0, tgt}) begin
            nxt = {1'b0, tgt};
         end
      end else if (cur > tgt) begin
         if (({1'b0, cur} - {1'b0, tgt}) > {1'b0, step}) begin
            nxt = {1'b0, cur} - {1'b0, step};
         end else begin
            nxt = {1'b0, tgt};
         end
      end
      return CH_W'(nxt);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and count; read data is the head, visible combinationally.
// Push is ignored when full, pop is ignored when empty; clr empties the queue and beats a same-cycle push.
module sync_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem[rd_ptr_q];
   assign push_ok = push && !full && !clr;
   assign pop_ok  = pop && !empty && !clr;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push_ok && !pop_ok)      count_d = count_q + (AW+1)'(1);
         else if (pop_ok && !push_ok) count_d = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/vga_color_fader.sv
// Frame-synchronous colour ramp feeding obj_color: queued targets are faded STEP per frame_tick, then held.
// obj_color changes only the cycle after frame_tick; tgt_ready = !full. FADER_FLUSH_EN adds a flush input.
module vga_color_fader
   import vga_pkg::*;
#(
   parameter int                 STEP        = 8,
   parameter int                 FIFO_DEPTH  = 4,
   parameter int                 HOLD_FRAMES = 60,
   parameter logic [COLOR_W-1:0] INIT_COLOR  = 24'h000000
) (
   input  logic               vga_clk,
   input  logic               rstn,
   input  logic [COLOR_W-1:0] tgt_color,
   input  logic               tgt_valid,
   output logic               tgt_ready,
   input  logic               frame_tick,
   output logic [COLOR_W-1:0] obj_color,
   output logic               busy
`ifdef FADER_FLUSH_EN
   ,
   input  logic               flush
`endif
);

   localparam int            AW        = $clog2(FIFO_DEPTH);
   localparam int            HW        = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES + 1) : 1;
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES);
   localparam logic [CH_W-1:0] STEP_C  = CH_W'(STEP);

   fader_state_t       state_q, state_d;
   rgb_t               color_q, color_d;
   rgb_t               tgt_q, tgt_d;
   rgb_t               stepped;
   logic [HW-1:0]      hold_q, hold_d;
   logic               busy_q, busy_d;
   logic               flush_w;
   logic               push, pop;
   logic               fifo_full, fifo_empty;
   logic [COLOR_W-1:0] fifo_rdata;
   logic [AW:0]        fifo_count, count_nxt;

`ifdef FADER_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   assign tgt_ready = !fifo_full && !flush_w;
   assign push      = tgt_valid && tgt_ready;
   assign pop       = (state_q == ST_IDLE) && !fifo_empty && !flush_w;
   assign obj_color = color_q;
   assign busy      = busy_q;

   sync_fifo #(
      .WIDTH (COLOR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (vga_clk),
      .rstn  (rstn),
      .clr   (flush_w),
      .push  (push),
      .wdata (tgt_color),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      stepped.r = step_ch(color_q.r, tgt_q.r, STEP_C);
      stepped.g = step_ch(color_q.g, tgt_q.g, STEP_C);
      stepped.b = step_ch(color_q.b, tgt_q.b, STEP_C);
   end

   always_comb begin
      state_d = state_q;
      color_d = color_q;
      tgt_d   = tgt_q;
      hold_d  = hold_q;
      if (flush_w) begin
         state_d = ST_IDLE;
         hold_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!fifo_empty) begin
                  tgt_d   = rgb_t'(fifo_rdata);
                  state_d = ST_FADE;
               end
            end
            ST_FADE: begin
               if (frame_tick) begin
                  color_d = stepped;
                  if (stepped == tgt_q) begin
                     if (HOLD_FRAMES == 0) begin
                        state_d = ST_IDLE;
                     end else begin
                        state_d = ST_HOLD;
                        hold_d  = HOLD_INIT;
                     end
                  end
               end
            end
            ST_HOLD: begin
               if (frame_tick) begin
                  hold_d = hold_q - HW'(1);
                  if (hold_q == HW'(1)) state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // busy is registered from next-state values so it tracks state and queue occupancy without lag.
   always_comb begin
      count_nxt = fifo_count;
      if (flush_w)           count_nxt = '0;
      else if (push && !pop) count_nxt = fifo_count + (AW+1)'(1);
      else if (pop && !push) count_nxt = fifo_count - (AW+1)'(1);
      busy_d = (state_d != ST_IDLE) || (count_nxt != '0);
   end

   always_ff @(posedge vga_clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         color_q <= rgb_t'(INIT_COLOR);
         tgt_q   <= rgb_t'(INIT_COLOR);
         hold_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         color_q <= color_d;
         tgt_q   <= tgt_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
      end
   end

endmodule
